// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot-image loader that streams words into IM/DM SRAMs.
package loader_pkg;

  localparam int unsigned IM_WORDS_DEF = 16384;
  localparam int unsigned DM_WORDS_DEF = 16384;
  localparam int unsigned WCNT_W       = 15;
  localparam int unsigned ADDR_W       = 14;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned WEB_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One SRAM write port as seen on the pins.
  typedef struct packed {
    logic              cs;
    logic [WEB_W-1:0]  web;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] di;
  } sram_wr_t;

  localparam sram_wr_t SRAM_IDLE = '{cs: 1'b0, web: {WEB_W{1'b1}}, a: '0, di: '0};

endpackage

// File: rtl/mem_loader.sv
// Streams an image into IM then DM through registered write ports, holding the CPU
// in reset until the final write has issued.
module mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned IM_WORDS = IM_WORDS_DEF,
  parameter int unsigned DM_WORDS = DM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_cs,
  output logic [WEB_W-1:0]  im_web,
  output logic [ADDR_W-1:0] im_a,
  output logic [DATA_W-1:0] im_di,
  output logic              dm_cs,
  output logic [WEB_W-1:0]  dm_web,
  output logic [ADDR_W-1:0] dm_a,
  output logic [DATA_W-1:0] dm_di,
  output logic              cpu_rst,
  output logic              done,
  output logic              err_ovf
);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  sram_wr_t            im_q, im_d, dm_q, dm_d;
  logic                in_ready_q, in_ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_ovf_q, err_ovf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      im_q       <= SRAM_IDLE;
      dm_q       <= SRAM_IDLE;
      in_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      im_q       <= im_d;
      dm_q       <= dm_d;
      in_ready_q <= in_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Next state, address decode and write-port staging.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    im_d      = SRAM_IDLE;
    dm_d      = SRAM_IDLE;
    err_ovf_d = err_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          wcnt_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (32'(wcnt_q) < IM_WORDS) begin
            im_d = '{cs: 1'b1, web: '0, a: wcnt_q[ADDR_W-1:0], di: in_data};
          end else begin
            dm_d = '{cs: 1'b1, web: '0, a: ADDR_W'(32'(wcnt_q) - IM_WORDS), di: in_data};
          end
          // Stop on the tagged last word or when both memories are full.
          if (in_last || (32'(wcnt_q) == IM_WORDS + DM_WORDS - 32'd1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (in_valid) err_ovf_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD);
    cpu_rst_d  = (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  assign in_ready = in_ready_q;
  assign im_cs    = im_q.cs;
  assign im_web   = im_q.web;
  assign im_a     = im_q.a;
  assign im_di    = im_q.di;
  assign dm_cs    = dm_q.cs;
  assign dm_web   = dm_q.web;
  assign dm_a     = dm_q.a;
  assign dm_di    = dm_q.di;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err_ovf  = err_ovf_q;

endmodule
